// File: rtl/digit_row_renderer_if.sv
// Signal bundle between the digit row renderer, the VGA timing generator,
// the digit ROM bank and the colour mux. The renderer uses the master side.
interface digit_row_renderer_if;
    logic         pix_en;     // one-clk pixel tick
    logic [9:0]   hcount;     // current pixel column
    logic [9:0]   vcount;     // current line
    logic         vid_on;     // active-video flag
    logic [3:0]   digit_in;   // glyph value, 1..9 valid
    logic [9:0]   org_x;      // glyph left column
    logic [9:0]   org_y;      // glyph top line
    logic [6:0]   rom_addr;   // row index to ROM bank
    logic [3:0]   rom_digit;  // glyph select to ROM bank (glyph-1)
    logic [127:0] rom_data;   // ROM row, valid one clk after address change
    logic         pix_out;    // serialized glyph pixel
    logic         busy;       // fetch or render in progress

    modport master (
        input  pix_en, hcount, vcount, vid_on, digit_in, org_x, org_y, rom_data,
        output rom_addr, rom_digit, pix_out, busy
    );

    modport slave (
        output pix_en, hcount, vcount, vid_on, digit_in, org_x, org_y, rom_data,
        input  rom_addr, rom_digit, pix_out, busy
    );
endinterface

// File: rtl/digit_row_renderer.sv
// Digit row renderer: during horizontal blanking it fetches the glyph row
// for the next scan line from the digit ROM bank, latches it, and on that
// line shifts it out MSB-first as a 1-bit pixel stream from column org_x.
// The first bit is emitted on the tick where hcount matches org_x, so
// pix_out lags the column it belongs to by exactly one pixel tick.
module digit_row_renderer #(
    parameter int SPRITE_H = 128,  // glyph height in rows, at most 128
    parameter int H_ACTIVE = 640,  // visible pixels per line
    parameter int H_LOAD   = 640,  // column where the next-line fetch is evaluated
    parameter int V_TOTAL  = 525   // lines per frame
) (
    input  logic                 clk,
    input  logic                 reset,
    digit_row_renderer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WAIT_X,
        S_SHIFT
    } state_e;

    state_e         state_q, state_d;
    logic [6:0]     rom_addr_q, rom_addr_d;
    logic [3:0]     rom_digit_q, rom_digit_d;
    logic [127:0]   line_buf_q, line_buf_d;
    logic [6:0]     bit_cnt_q, bit_cnt_d;
    logic           pix_q, pix_d;

    logic [9:0]     next_line;
    logic [9:0]     row;
    logic           digit_ok;
    logic           at_load;
    logic           fetch_ok;
    logic           x_match;

    // Next-line arithmetic and the fetch / origin match conditions.
    always_comb begin
        next_line = (bus.vcount == 10'(V_TOTAL - 1)) ? 10'd0 : bus.vcount + 10'd1;
        // Unsigned 10-bit difference: lines above org_y wrap to a large value
        // and fail the height test below.
        row       = next_line - bus.org_y;
        digit_ok  = (bus.digit_in >= 4'd1) && (bus.digit_in <= 4'd9);
        at_load   = bus.pix_en && (bus.hcount == 10'(H_LOAD));
        fetch_ok  = at_load && (row < 10'(SPRITE_H)) && digit_ok;
        // The origin only matches inside the visible region, so an org_x in
        // blanking never starts a render and WAIT_X is left at H_LOAD instead.
        x_match   = bus.pix_en && (bus.hcount == bus.org_x) &&
                    (bus.hcount < 10'(H_ACTIVE));
    end

    // Next-state and datapath decode for fetch, latch, wait and shift.
    always_comb begin
        // NOTE: every _d takes its _q value first, so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        rom_digit_d = rom_digit_q;
        line_buf_d  = line_buf_q;
        bit_cnt_d   = bit_cnt_q;
        pix_d       = pix_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.pix_en) begin
                    pix_d = 1'b0;
                end
                if (fetch_ok) begin
                    rom_addr_d  = row[6:0];
                    rom_digit_d = bus.digit_in - 4'd1;
                    state_d     = S_FETCH;
                end
            end

            S_FETCH: begin
                // Give the ROM a full pixel tick to settle on the new address.
                if (bus.pix_en) begin
                    pix_d   = 1'b0;
                    state_d = S_LATCH;
                end
            end

            S_LATCH: begin
                // Single clk, independent of pix_en.
                line_buf_d = bus.rom_data;
                bit_cnt_d  = 7'd0;
                state_d    = S_WAIT_X;
            end

            S_WAIT_X, S_SHIFT: begin
                if (at_load) begin
                    // Clip at the load column: drop the unsent bits and
                    // evaluate the next-line fetch exactly as IDLE would.
                    pix_d      = 1'b0;
                    line_buf_d = '0;
                    state_d    = S_IDLE;
                    if (fetch_ok) begin
                        rom_addr_d  = row[6:0];
                        rom_digit_d = bus.digit_in - 4'd1;
                        state_d     = S_FETCH;
                    end
                end else if ((state_q == S_SHIFT && bus.pix_en) ||
                             (state_q == S_WAIT_X && x_match)) begin
                    pix_d      = line_buf_q[127] & bus.vid_on;
                    line_buf_d = {line_buf_q[126:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q + 7'd1;
                    if (state_q == S_WAIT_X) begin
                        state_d = S_SHIFT;
                    end else if (bit_cnt_q == 7'd127) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= 7'd0;
            rom_digit_q <= 4'd0;
            // NOTE: the row buffer is cleared on reset so a stale glyph row can never be shifted out.
            line_buf_q  <= '0;
            bit_cnt_q   <= 7'd0;
            pix_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            rom_digit_q <= rom_digit_d;
            line_buf_q  <= line_buf_d;
            bit_cnt_q   <= bit_cnt_d;
            pix_q       <= pix_d;
        end
    end

    // Output drive.
    always_comb begin
        bus.rom_addr  = rom_addr_q;
        bus.rom_digit = rom_digit_q;
        bus.pix_out   = pix_q;
        bus.busy      = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_digit_row_renderer.sv
// Testbench for digit_row_renderer: drives a VGA-style raster (800 x 525,
// one pixel tick every second clk), models the ROM bank, and compares the
// DUT each pixel tick against a line-level model of what should be drawn.
module tb_digit_row_renderer;

    localparam int H_TOTAL = 800;
    localparam int V_TOT   = 525;
    localparam int H_LD    = 640;

    logic clk = 1'b0;
    logic reset;

    digit_row_renderer_if bus_if ();

    digit_row_renderer #(
        .SPRITE_H (128),
        .H_ACTIVE (640),
        .H_LOAD   (H_LD),
        .V_TOTAL  (V_TOT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Raster position currently presented to the DUT.
    int cur_v;
    int cur_h;

    // Line-level model: one pending glyph row and the ROM outputs expected.
    bit           m_pend;
    int           m_line;
    int           m_x;
    logic [127:0] m_bits;
    logic [6:0]   m_addr;
    logic [3:0]   m_digit;

    // Captured outputs of one line, indexed by column.
    logic cap_pix  [H_TOTAL];
    logic cap_busy [H_TOTAL];
    int   cap_line = -1;

    // ROM bank contents: glyph 5 row 0 and glyph 3 are special, the rest
    // carry a byte pattern identifying select and row.
    function automatic logic [127:0] rom_fn(logic [3:0] sel, logic [6:0] row);
        logic [7:0] b;
        if (sel == 4'd4 && row == 7'd0) return {4'hF, 123'd0, 1'b1};
        if (sel == 4'd2) return {128{1'b1}};
        b = {sel, row[3:0]} ^ 8'h5A;
        return {16{b}};
    endfunction

    // ROM data follows the address one clk later.
    always @(posedge clk) bus_if.rom_data <= rom_fn(bus_if.rom_digit, bus_if.rom_addr);

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_pos(int v, int h);
        cur_v          = v;
        cur_h          = h;
        bus_if.vcount  = 10'(v);
        bus_if.hcount  = 10'(h);
        bus_if.vid_on  = (h < 640) && (v < 480);
    endtask

    task automatic set_cap(int line);
        cap_line = line;
        for (int i = 0; i < H_TOTAL; i++) begin
            cap_pix[i]  = 1'b0;
            cap_busy[i] = 1'b0;
        end
    endtask

    function automatic int cnt_pix();
        int n = 0;
        for (int i = 0; i < H_TOTAL; i++) if (cap_pix[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int cnt_busy();
        int n = 0;
        for (int i = 0; i < H_TOTAL; i++) if (cap_busy[i] === 1'b1) n++;
        return n;
    endfunction

    // One pixel tick: a quiet clk, then a clk with pix_en high; outputs are
    // sampled on the falling edge after the tick and compared to the model.
    task automatic tick();
        int   v, h, nl, row, dig, end_col;
        logic vid, exp_pix;
        v   = cur_v;
        h   = cur_h;
        vid = bus_if.vid_on;
        @(negedge clk);
        bus_if.pix_en = 1'b1;
        @(negedge clk);
        bus_if.pix_en = 1'b0;

        exp_pix = 1'b0;
        if (m_pend && v == m_line && h >= m_x && h < m_x + 128 && h < 640)
            exp_pix = m_bits[127 - (h - m_x)] & vid;
        end_col = (m_x + 127 < H_LD) ? m_x + 127 : H_LD;
        if (m_pend && v == m_line && h == end_col) m_pend = 1'b0;

        nl  = (v == V_TOT - 1) ? 0 : v + 1;
        row = nl - int'(bus_if.org_y);
        if (row < 0) row += 1024;
        dig = int'(bus_if.digit_in);
        if (h == H_LD && row < 128 && dig >= 1 && dig <= 9) begin
            m_pend  = 1'b1;
            m_line  = nl;
            m_x     = int'(bus_if.org_x);
            m_addr  = 7'(row);
            m_digit = 4'(dig - 1);
            m_bits  = rom_fn(m_digit, m_addr);
        end

        check($sformatf("pix_out@%0d,%0d", v, h), bus_if.pix_out, exp_pix);
        check($sformatf("busy@%0d,%0d", v, h), bus_if.busy, m_pend);
        check($sformatf("rom_addr@%0d,%0d", v, h), bus_if.rom_addr, m_addr);
        check($sformatf("rom_digit@%0d,%0d", v, h), bus_if.rom_digit, m_digit);

        if (v == cap_line) begin
            cap_pix[h]  = bus_if.pix_out;
            cap_busy[h] = bus_if.busy;
        end

        h++;
        if (h == H_TOTAL) begin
            h = 0;
            v = (v == V_TOT - 1) ? 0 : v + 1;
        end
        set_pos(v, h);
    endtask

    task automatic run_to(int v, int h);
        int n = 0;
        while (!(cur_v == v && cur_h == h)) begin
            tick();
            n++;
            if (n > 5000) begin
                check($sformatf("run_to_timeout(%0d,%0d)", v, h), 1'b1, 1'b0);
                break;
            end
        end
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset   = 1'b0;
        m_pend  = 1'b0;
        m_addr  = 7'd0;
        m_digit = 4'd0;
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_pix_out"}, bus_if.pix_out, 1'b0);
        check({tag, "_busy"}, bus_if.busy, 1'b0);
        check({tag, "_rom_addr"}, bus_if.rom_addr, 7'd0);
        check({tag, "_rom_digit"}, bus_if.rom_digit, 4'd0);
    endtask

    task automatic start(int v, int h);
        do_reset(2);
        set_pos(v, h);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus_if.pix_en   = 1'b0;
        bus_if.digit_in = 4'd0;
        bus_if.org_x    = 10'd0;
        bus_if.org_y    = 10'd0;
        set_pos(0, 0);
        do_reset(3);
        check_reset_state("por");

        // Glyph 5 row 0 at (100,50): ones at 100..103 and 227.
        bus_if.digit_in = 4'd5;
        bus_if.org_x    = 10'd100;
        bus_if.org_y    = 10'd50;
        start(49, 630);
        set_cap(50);
        run_to(49, 641);
        check("g5_rom_digit", bus_if.rom_digit, 4'd4);
        check("g5_rom_addr", bus_if.rom_addr, 7'd0);
        check("g5_busy_after_fetch", bus_if.busy, 1'b1);
        run_to(51, 0);
        check("g5_ones_count", cnt_pix(), 5);
        check("g5_col100", cap_pix[100], 1'b1);
        check("g5_col103", cap_pix[103], 1'b1);
        check("g5_col104", cap_pix[104], 1'b0);
        check("g5_col226", cap_pix[226], 1'b0);
        check("g5_col227", cap_pix[227], 1'b1);
        check("g5_col228", cap_pix[228], 1'b0);
        check("g5_busy226", cap_busy[226], 1'b1);
        check("g5_busy227", cap_busy[227], 1'b0);

        // Reset held 3 clks in the middle of SHIFT, then a normal fetch.
        start(49, 630);
        run_to(50, 150);
        check("mid_shift_busy", bus_if.busy, 1'b1);
        do_reset(3);
        check_reset_state("mid_shift");
        run_to(50, 641);
        check("refetch_rom_addr", bus_if.rom_addr, 7'd1);
        check("refetch_rom_digit", bus_if.rom_digit, 4'd4);
        set_cap(51);
        run_to(52, 0);
        check("refetch_ones_count", cnt_pix(), 64);

        // row = 128: no fetch for line 178.
        start(177, 630);
        set_cap(178);
        run_to(179, 0);
        check("row128_pix_count", cnt_pix(), 0);
        check("row128_busy_count", cnt_busy(), 0);

        // Line above org_y: negative row wraps and is rejected.
        bus_if.org_y = 10'd300;
        start(100, 630);
        set_cap(101);
        run_to(102, 0);
        check("negrow_busy_count", cnt_busy(), 0);

        // Blank digit values 0 and 12, then digit 9.
        bus_if.org_x    = 10'd10;
        bus_if.org_y    = 10'd0;
        bus_if.digit_in = 4'd0;
        start(5, 630);
        set_cap(6);
        run_to(7, 0);
        check("digit0_busy_count", cnt_busy(), 0);
        bus_if.digit_in = 4'd12;
        start(5, 630);
        set_cap(6);
        run_to(7, 0);
        check("digit12_busy_count", cnt_busy(), 0);
        check("digit12_pix_count", cnt_pix(), 0);
        bus_if.digit_in = 4'd9;
        start(5, 630);
        run_to(5, 641);
        check("digit9_rom_digit", bus_if.rom_digit, 4'd8);
        check("digit9_rom_addr", bus_if.rom_addr, 7'd6);
        set_cap(6);
        run_to(7, 0);
        check("digit9_ones_count", cnt_pix(), 80);
        check("digit9_col9", cap_pix[9], 1'b0);
        check("digit9_col10", cap_pix[10], 1'b1);

        // Frame wrap: line 524 fetches row 0 for line 0.
        bus_if.org_x    = 10'd20;
        bus_if.org_y    = 10'd0;
        bus_if.digit_in = 4'd1;
        start(524, 630);
        run_to(524, 641);
        check("wrap_rom_addr", bus_if.rom_addr, 7'd0);
        check("wrap_rom_digit", bus_if.rom_digit, 4'd0);
        check("wrap_busy", bus_if.busy, 1'b1);
        set_cap(0);
        run_to(1, 0);
        check("wrap_ones_count", cnt_pix(), 64);
        check("wrap_col20", cap_pix[20], 1'b0);
        check("wrap_col21", cap_pix[21], 1'b1);

        // Clip at 640 with an all-ones row; digit change mid-SHIFT.
        bus_if.org_x    = 10'd600;
        bus_if.org_y    = 10'd200;
        bus_if.digit_in = 4'd3;
        start(199, 630);
        set_cap(200);
        run_to(200, 620);
        check("clip_busy_mid", bus_if.busy, 1'b1);
        bus_if.digit_in = 4'd7;
        run_to(200, 641);
        check("clip_next_rom_digit", bus_if.rom_digit, 4'd6);
        check("clip_next_rom_addr", bus_if.rom_addr, 7'd1);
        run_to(201, 0);
        check("clip_ones_count", cnt_pix(), 40);
        check("clip_col599", cap_pix[599], 1'b0);
        check("clip_col600", cap_pix[600], 1'b1);
        check("clip_col639", cap_pix[639], 1'b1);
        check("clip_col640", cap_pix[640], 1'b0);
        set_cap(201);
        run_to(202, 0);
        check("clip_next_ones_count", cnt_pix(), 25);

        // Glyph on a line outside active video: busy but dark.
        bus_if.org_x    = 10'd50;
        bus_if.org_y    = 10'd470;
        bus_if.digit_in = 4'd3;
        start(479, 630);
        set_cap(480);
        run_to(481, 0);
        check("vidoff_pix_count", cnt_pix(), 0);
        check("vidoff_busy100", cap_busy[100], 1'b1);
        check("vidoff_busy177", cap_busy[177], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
